// File: rtl/stopwatch_ctrl_if.sv
// Button, count and display signals between the board/counter side and the stopwatch control FSM.
// The master drives the buttons and live count; the slave (stopwatch_ctrl) returns controls and display data.
interface stopwatch_ctrl_if #(
    parameter int CNT_W     = 17,
    parameter int LAP_DEPTH = 4
);
    localparam int SEL_W = $clog2(LAP_DEPTH);

    logic             sw;
    logic             btn_ss;
    logic             btn_lr;
    logic [CNT_W-1:0] sec_cnt;
    logic [SEL_W-1:0] lap_sel;
    logic             swp;
    logic             cnt_clr;
    logic             disp_frozen;
    logic [CNT_W-1:0] disp_cnt;
    logic [SEL_W:0]   lap_cnt;
    logic [CNT_W-1:0] lap_val;
    logic [1:0]       state;

    modport master (
        output sw, btn_ss, btn_lr, sec_cnt, lap_sel,
        input  swp, cnt_clr, disp_frozen, disp_cnt, lap_cnt, lap_val, state
    );

    modport slave (
        input  sw, btn_ss, btn_lr, sec_cnt, lap_sel,
        output swp, cnt_clr, disp_frozen, disp_cnt, lap_cnt, lap_val, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions start/stop and lap/reset buttons, drives counter pause/clear,
// freezes the display on laps and keeps a circular buffer of the most recent lap times.
module stopwatch_ctrl #(
    parameter int CNT_W     = 17,
    parameter int LAP_DEPTH = 4
) (
    input  logic               clk_out,
    input  logic               swrst,
    stopwatch_ctrl_if.slave    bus
);
    localparam int SEL_W = $clog2(LAP_DEPTH);
    localparam logic [SEL_W:0] LAP_FULL = (SEL_W+1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        LAPVIEW = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic             cnt_clr_reg, cnt_clr_next;
    logic             capture, push, wipe;
    logic [CNT_W-1:0] hold_reg;
    logic [SEL_W-1:0] wr_ptr_reg;
    logic [SEL_W:0]   lap_cnt_reg;
    logic [CNT_W-1:0] lap_mem [LAP_DEPTH];
    logic [SEL_W-1:0] rd_idx;
    logic [1:0]       vld_reg;
    logic [1:0]       btn_raw;
    logic [1:0]       press;
    logic             ss_press, lr_press;

    // vld_reg[1] marks the first cycle the synchronizer outputs reflect real button samples
    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst) vld_reg <= '0;
        else       vld_reg <= {vld_reg[0], 1'b1};
    end

    assign btn_raw = {bus.btn_lr, bus.btn_ss};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic s1_reg, s2_reg, edge_reg, armed_reg;

        // A button held through reset stays disarmed until it has been seen released
        always_ff @(posedge clk_out or posedge swrst) begin
            if (swrst) begin
                s1_reg    <= 1'b0;
                s2_reg    <= 1'b0;
                edge_reg  <= 1'b0;
                armed_reg <= 1'b0;
            end else begin
                s1_reg    <= btn_raw[gi];
                s2_reg    <= s1_reg;
                edge_reg  <= s2_reg;
                armed_reg <= armed_reg | (vld_reg[1] & ~s2_reg);
            end
        end

        assign press[gi] = s2_reg & ~edge_reg & armed_reg;
    end

    assign ss_press = press[0] & bus.sw;
    assign lr_press = press[1] & bus.sw & ~ss_press;

    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst) begin
            state_reg   <= IDLE;
            cnt_clr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_clr_reg <= cnt_clr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_clr_next    = 1'b0;
        capture         = 1'b0;
        push            = 1'b0;
        wipe            = 1'b0;
        bus.swp         = 1'b1;
        bus.disp_frozen = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ss_press)      state_next = RUN;
                else if (lr_press) cnt_clr_next = 1'b1;
            end
            RUN: begin
                bus.swp = 1'b0;
                if (ss_press) begin
                    state_next = PAUSE;
                end else if (lr_press) begin
                    state_next = LAPVIEW;
                    capture    = 1'b1;
                    push       = 1'b1;
                end
            end
            LAPVIEW: begin
                bus.swp         = 1'b0;
                bus.disp_frozen = 1'b1;
                if (ss_press) begin
                    state_next = PAUSE;
                end else if (lr_press) begin
                    capture = 1'b1;
                    push    = 1'b1;
                end
            end
            PAUSE: begin
                if (ss_press) begin
                    state_next = RUN;
                end else if (lr_press) begin
                    state_next   = IDLE;
                    cnt_clr_next = 1'b1;
                    wipe         = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst)        hold_reg <= '0;
        else if (capture) hold_reg <= bus.sec_cnt;
    end

    // Lap buffer: wr_ptr points at the slot the next push overwrites (the oldest once full)
    always_ff @(posedge clk_out or posedge swrst) begin
        if (swrst) begin
            wr_ptr_reg  <= '0;
            lap_cnt_reg <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else if (wipe) begin
            wr_ptr_reg  <= '0;
            lap_cnt_reg <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
        end else if (push) begin
            lap_mem[wr_ptr_reg] <= bus.sec_cnt;
            wr_ptr_reg          <= wr_ptr_reg + SEL_W'(1);
            if (lap_cnt_reg != LAP_FULL) lap_cnt_reg <= lap_cnt_reg + (SEL_W+1)'(1);
        end
    end

    assign rd_idx      = wr_ptr_reg - SEL_W'(1) - bus.lap_sel;
    assign bus.lap_val = ({1'b0, bus.lap_sel} < lap_cnt_reg) ? lap_mem[rd_idx] : '0;
    assign bus.lap_cnt = lap_cnt_reg;
    assign bus.disp_cnt = bus.disp_frozen ? hold_reg : bus.sec_cnt;
    assign bus.cnt_clr = cnt_clr_reg;
    assign bus.state   = state_reg;
endmodule
